// File: rtl/div_unit.sv
// div_unit - iterative radix-2 restoring divider for DIV/DIVU.
//   A start pulse captures operand magnitudes and signs, then one quotient bit
//   is produced per clock. Quotient (to LO) and remainder (to HI) are published
//   with a one-cycle done pulse; a zero divisor short-circuits straight to the
//   result stage with q = all ones and r = dividend.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   start     request, sampled only while busy = 0
//   sgn       1 = signed (DIV), 0 = unsigned (DIVU), captured with start
//   a, b      dividend / divisor, captured with start
//   busy      operation in progress (start ignored)
//   done      one-cycle pulse, q/r/div_zero valid
//   div_zero  last operation had b == 0, held until next accepted start
//   q, r      registered quotient / remainder, held until next done
module div_unit #(
  parameter int wide = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sgn,
  input  logic [wide-1:0] a,
  input  logic [wide-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [wide-1:0] q,
  output logic [wide-1:0] r
);

  localparam int CNT_W = $clog2(wide);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(wide - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  // The partial remainder is always below |b| after each step, so wide bits
  // hold it; only the trial value t needs the extra bit.
  logic [wide-1:0]  rem_q, rem_d;
  logic [wide-1:0]  quo_q, quo_d;
  logic [wide-1:0]  bmag_q, bmag_d;
  logic [wide-1:0]  araw_q, araw_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             bzero_q, bzero_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [wide-1:0]  q_q, q_d;
  logic [wide-1:0]  r_q, r_d;
  logic [wide:0]    t;

  function automatic logic [wide-1:0] negate(input logic [wide-1:0] x);
    return wide'(0) - x;
  endfunction

  function automatic logic [wide-1:0] magnitude(input logic [wide-1:0] x, input logic neg);
    return neg ? negate(x) : x;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bmag_q  <= '0;
      araw_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      bzero_q <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bmag_q  <= bmag_d;
      araw_q  <= araw_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      bzero_q <= bzero_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (b == '0) ? S_FIN : S_RUN;
      S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bmag_d  = bmag_q;
    araw_d  = araw_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    bzero_d = bzero_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    q_d     = q_q;
    r_d     = r_q;
    t       = {rem_q, quo_q[wide-1]};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          quo_d   = magnitude(a, sgn & a[wide-1]);
          bmag_d  = magnitude(b, sgn & b[wide-1]);
          neg_q_d = sgn & (a[wide-1] ^ b[wide-1]);
          neg_r_d = sgn & a[wide-1];
          araw_d  = a;
          bzero_d = (b == '0);
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = 1'b0;
        end
      end
      S_RUN: begin
        // Restoring step: shift the next dividend bit in and subtract if it fits.
        if (t >= {1'b0, bmag_q}) begin
          rem_d = wide'(t - {1'b0, bmag_q});
          quo_d = {quo_q[wide-2:0], 1'b1};
        end else begin
          rem_d = t[wide-1:0];
          quo_d = {quo_q[wide-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIN: begin
        done_d = 1'b1;
        if (bzero_q) begin
          q_d  = '1;
          r_d  = araw_q;
          dz_d = 1'b1;
        end else begin
          q_d  = neg_q_q ? negate(quo_q) : quo_q;
          r_d  = neg_r_q ? negate(rem_q) : rem_q;
          dz_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = done_q;
    div_zero = dz_q;
    q        = q_q;
    r        = r_q;
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] q, r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  div_unit #(.wide(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .q(q), .r(r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating division, remainder takes the dividend's sign,
  // computed in 64-bit so the most-negative / -1 case wraps naturally.
  task automatic model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] mq, output logic [W-1:0] mr);
    longint lx, ly;
    if (y == '0) begin
      mq = '1;
      mr = x;
    end else begin
      if (s) begin
        lx = longint'($signed(x));
        ly = longint'($signed(y));
      end else begin
        lx = longint'({32'b0, x});
        ly = longint'({32'b0, y});
      end
      mq = W'(lx / ly);
      mr = W'(lx % ly);
    end
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] mq, mr;
    int e0, at;
    model(s, x, y, mq, mr);
    @(negedge clk);
    start = 1'b1; sgn = s; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    start = 1'b0;
    // operands scrambled after capture must not disturb the result
    a = $urandom; b = $urandom; sgn = 1'($urandom);
    wait_done(at);
    if (at >= 0) begin
      check_val({tag, "_lat"}, W'(at - e0), (y == '0) ? 32'd1 : 32'd33);
      check_val({tag, "_q"}, q, mq);
      check_val({tag, "_r"}, r, mr);
      check_val({tag, "_dz"}, {31'b0, div_zero}, {31'b0, (y == '0)});
      @(negedge clk);
      check_val({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
      check_val({tag, "_q_hold"}, q, mq);
    end
  endtask

  initial begin
    int at, e0, ndone;
    logic [W-1:0] x, y, corner[6];
    logic s;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_dz", {31'b0, div_zero}, 32'd0);
    check_val("rst_q", q, 32'd0);
    check_val("rst_r", r, 32'd0);
    rst = 1'b1;

    // Directed cases
    run_op("udiv", 1'b0, 32'd100, 32'd7);
    run_op("sdiv", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("dz", 1'b0, 32'd5, 32'd0);
    run_op("sdz", 1'b1, 32'hFFFF_FFF0, 32'd0);
    run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("ubig", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("snegb", 1'b1, 32'd7, 32'hFFFF_FFFE);

    // Start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; a = 32'd9; b = 32'd3;
    check_val("busy_mid", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(at);
    check_val("busy_q", q, 32'd14);
    check_val("busy_r", r, 32'd2);
    start = 1'b1; a = 32'd9; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    start = 1'b0;
    check_val("b2b_done_low", {31'b0, done}, 32'd0);
    check_val("b2b_busy", {31'b0, busy}, 32'd1);
    wait_done(at);
    check_val("b2b_lat", W'(at - e0), 32'd33);
    check_val("b2b_q", q, 32'd3);
    check_val("b2b_r", r, 32'd0);

    // Reset mid-operation abandons the result
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_val("mrst_busy", {31'b0, busy}, 32'd0);
    check_val("mrst_done", {31'b0, done}, 32'd0);
    check_val("mrst_q", q, 32'd0);
    check_val("mrst_r", r, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_val("mrst_no_done", W'(ndone), 32'd0);

    // Randomized operations against the reference
    corner[0] = 32'h8000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'd1;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'd2; corner[5] = 32'h0001_0000;
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom);
      x = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) y = W'($urandom_range(1, 300));
      if (y == '0) y = 32'd3;
      run_op("rand", s, x, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
